// File: rtl/read_path_arbiter_if.sv
// Read-path arbitration bundle: master request/handshake inputs and path-select outputs.
// The arbiter takes the slave modport; the environment that drives requests takes the master modport.
interface read_path_arbiter_if;
  logic       ARVALID_M0;
  logic       ARVALID_M1;
  logic       ARVALID_M2;
  logic [3:0] SLV_M0;
  logic [3:0] SLV_M1;
  logic [3:0] SLV_M2;
  logic       ARREADY_SEL;
  logic       RVALID_SEL;
  logic       RREADY_SEL;
  logic       RLAST_SEL;
  logic [5:0] AR_arbiter;
  logic [2:0] GNT_M;
  logic       BUSY;
  logic       RD_TIMEOUT;

  modport master (
    output ARVALID_M0, ARVALID_M1, ARVALID_M2,
    output SLV_M0, SLV_M1, SLV_M2,
    output ARREADY_SEL, RVALID_SEL, RREADY_SEL, RLAST_SEL,
    input  AR_arbiter, GNT_M, BUSY, RD_TIMEOUT
  );

  modport slave (
    input  ARVALID_M0, ARVALID_M1, ARVALID_M2,
    input  SLV_M0, SLV_M1, SLV_M2,
    input  ARREADY_SEL, RVALID_SEL, RREADY_SEL, RLAST_SEL,
    output AR_arbiter, GNT_M, BUSY, RD_TIMEOUT
  );
endinterface

// File: rtl/read_path_arbiter.sv
// Round-robin AXI read-path arbiter (3 masters, 8 slaves + default slave); one burst in flight.
// Optional read watchdog enabled by defining RD_TIMEOUT_EN.
module read_path_arbiter #(
  parameter int MST_NUM        = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  read_path_arbiter_if.slave   rd_if
);

  localparam logic [5:0] AR_IDLE = 6'h3F;

  if (MST_NUM != 3) begin : g_bad_mst_num
    $error("read_path_arbiter supports exactly 3 masters");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("read_path_arbiter TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_ptr, w_ptr_nxt;
  logic [5:0]         r_ar_arbiter, w_ar_nxt;
  logic [MST_NUM-1:0] r_gnt, w_gnt_nxt;
  logic               r_busy, w_busy_nxt;

  logic [2:0] w_req;
  logic [1:0] w_pick;
  logic       w_pick_vld;
  logic [3:0] w_slv_pick;
  logic [3:0] w_slv_code;
  logic [1:0] w_own;
  logic       w_own_arvalid;
  logic       w_ar_hs;
  logic       w_beat;
  logic       w_last_beat;
  logic       w_timeout;

  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign w_req       = {rd_if.ARVALID_M2, rd_if.ARVALID_M1, rd_if.ARVALID_M0};
  assign w_own       = r_ar_arbiter[5:4];
  assign w_beat      = rd_if.RVALID_SEL & rd_if.RREADY_SEL;
  assign w_last_beat = w_beat & rd_if.RLAST_SEL;
  assign w_ar_hs     = w_own_arvalid & rd_if.ARREADY_SEL;

  // Search order starts at the pointer and wraps modulo 3.
  always_comb begin
    logic [1:0] o1;
    logic [1:0] o2;
    o1         = inc_mod3(r_ptr);
    o2         = inc_mod3(o1);
    w_pick_vld = |w_req;
    if (w_req[r_ptr])   w_pick = r_ptr;
    else if (w_req[o1]) w_pick = o1;
    else                w_pick = o2;
  end

  always_comb begin
    case (w_pick)
      2'd0:    w_slv_pick = rd_if.SLV_M0;
      2'd1:    w_slv_pick = rd_if.SLV_M1;
      default: w_slv_pick = rd_if.SLV_M2;
    endcase
    case (w_own)
      2'd0:    w_own_arvalid = rd_if.ARVALID_M0;
      2'd1:    w_own_arvalid = rd_if.ARVALID_M1;
      2'd2:    w_own_arvalid = rd_if.ARVALID_M2;
      default: w_own_arvalid = 1'b0;
    endcase
  end

  // Unmapped codes 9-15 collapse onto the default (DECERR) slave.
  assign w_slv_code = (w_slv_pick > 4'd8) ? 4'd8 : w_slv_pick;

`ifdef RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_rd_timeout;

  assign w_timeout = (r_state != S_IDLE) && !w_beat &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_cnt        <= '0;
      r_rd_timeout <= 1'b0;
    end else begin
      r_rd_timeout <= w_timeout;
      if (r_state == S_IDLE || w_beat || w_timeout) r_cnt <= '0;
      else                                          r_cnt <= r_cnt + 1'b1;
    end
  end

  assign rd_if.RD_TIMEOUT = r_rd_timeout;
`else
  assign w_timeout        = 1'b0;
  assign rd_if.RD_TIMEOUT = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= S_IDLE;
      r_ptr        <= 2'd0;
      r_ar_arbiter <= AR_IDLE;
      r_gnt        <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_ar_arbiter <= w_ar_nxt;
      r_gnt        <= w_gnt_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // NOTE: every comb output gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_pick_vld) w_state_nxt = S_ADDR;
      S_ADDR: begin
        if (w_timeout)    w_state_nxt = S_IDLE;
        else if (w_ar_hs) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_timeout || w_last_beat) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ar_nxt   = r_ar_arbiter;
    w_gnt_nxt  = r_gnt;
    w_busy_nxt = r_busy;
    w_ptr_nxt  = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_ar_nxt   = {w_pick, w_slv_code};
          w_gnt_nxt  = MST_NUM'(1) << w_pick;
          w_busy_nxt = 1'b1;
        end else begin
          w_ar_nxt   = AR_IDLE;
          w_gnt_nxt  = '0;
          w_busy_nxt = 1'b0;
        end
      end
      S_ADDR: begin
        if (w_timeout) begin
          w_ar_nxt   = AR_IDLE;
          w_gnt_nxt  = '0;
          w_busy_nxt = 1'b0;
          w_ptr_nxt  = inc_mod3(w_own);
        end else if (w_ar_hs) begin
          w_gnt_nxt  = '0;
          w_ptr_nxt  = inc_mod3(w_own);
        end
      end
      S_DATA: begin
        w_gnt_nxt = '0;
        if (w_timeout || w_last_beat) begin
          w_ar_nxt   = AR_IDLE;
          w_busy_nxt = 1'b0;
          w_ptr_nxt  = inc_mod3(w_own);
        end
      end
      default: begin
        w_ar_nxt   = AR_IDLE;
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign rd_if.AR_arbiter = r_ar_arbiter;
  assign rd_if.GNT_M      = r_gnt;
  assign rd_if.BUSY       = r_busy;

endmodule

// File: tb/tb_read_path_arbiter.sv
// Self-checking bench for read_path_arbiter: directed steps plus random traffic against a
// transaction-level reference model (owner / phase / pointer).
module tb_read_path_arbiter;

  localparam int T_CYC = 16;
`ifdef RD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  read_path_arbiter_if rd_if();

  read_path_arbiter #(.MST_NUM(3), .TIMEOUT_CYCLES(T_CYC)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .rd_if  (rd_if)
  );

  int n_pass   = 0;
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, whether the address is still pending, and rotation pointer.
  int         m_owner;
  int         m_ptr;
  int         m_stall;
  bit         m_addr;
  logic [3:0] m_slv;
  logic       m_to;

  function automatic logic arv(int m);
    case (m)
      0:       return rd_if.ARVALID_M0;
      1:       return rd_if.ARVALID_M1;
      default: return rd_if.ARVALID_M2;
    endcase
  endfunction

  function automatic logic [3:0] slv_of(int m);
    case (m)
      0:       return rd_if.SLV_M0;
      1:       return rd_if.SLV_M1;
      default: return rd_if.SLV_M2;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_stall = 0;
    m_addr  = 1'b0;
    m_slv   = 4'd0;
    m_to    = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently presented to the DUT.
  task automatic model_update();
    logic beat;
    int   m;
    beat = rd_if.RVALID_SEL & rd_if.RREADY_SEL;
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 3; k++) begin
        m = (m_ptr + k) % 3;
        if (m_owner < 0 && arv(m)) begin
          m_owner = m;
          m_slv   = (slv_of(m) > 4'd8) ? 4'd8 : slv_of(m);
          m_addr  = 1'b1;
          m_stall = 0;
        end
      end
    end else if (TO_EN && !beat && m_stall == T_CYC - 1) begin
      m_to    = 1'b1;
      m_ptr   = (m_owner + 1) % 3;
      m_owner = -1;
    end else begin
      m_stall = beat ? 0 : m_stall + 1;
      if (m_addr) begin
        if (arv(m_owner) && rd_if.ARREADY_SEL) begin
          m_addr = 1'b0;
          m_ptr  = (m_owner + 1) % 3;
        end
      end else if (beat && rd_if.RLAST_SEL) begin
        m_owner = -1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [5:0] e_ar;
    logic [2:0] e_gnt;
    e_ar  = (m_owner < 0) ? 6'h3F : {m_owner[1:0], m_slv};
    e_gnt = (m_owner >= 0 && m_addr) ? 3'(1 << m_owner) : 3'b000;
    check({tag, "_ar"},   8'(rd_if.AR_arbiter), 8'(e_ar));
    check({tag, "_gnt"},  8'(rd_if.GNT_M),      8'(e_gnt));
    check({tag, "_busy"}, 8'(rd_if.BUSY),       8'(m_owner >= 0));
    check({tag, "_to"},   8'(rd_if.RD_TIMEOUT), 8'(m_to));
  endtask

  task automatic step(input string tag);
    model_update();
    @(posedge ACLK);
    @(negedge ACLK);
    check_outputs(tag);
  endtask

  task automatic clear_inputs();
    rd_if.ARVALID_M0  = 1'b0;
    rd_if.ARVALID_M1  = 1'b0;
    rd_if.ARVALID_M2  = 1'b0;
    rd_if.SLV_M0      = 4'd0;
    rd_if.SLV_M1      = 4'd0;
    rd_if.SLV_M2      = 4'd0;
    rd_if.ARREADY_SEL = 1'b0;
    rd_if.RVALID_SEL  = 1'b0;
    rd_if.RREADY_SEL  = 1'b0;
    rd_if.RLAST_SEL   = 1'b0;
  endtask

  task automatic set_r(input logic rv, input logic rr, input logic rl);
    rd_if.RVALID_SEL = rv;
    rd_if.RREADY_SEL = rr;
    rd_if.RLAST_SEL  = rl;
  endtask

  initial begin
    int order[4];
    int pulses;
    int pulse_at;
    order = '{0, 1, 2, 0};

    // Reset
    ARESET = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge ACLK);
    check_outputs("reset");
    check("reset_ar_const", 8'(rd_if.AR_arbiter), 8'h3F);
    ARESET = 1'b0;
    step("idle");

    // M1 -> S2 grant, address handshake, 4-beat burst
    rd_if.ARVALID_M1 = 1'b1;
    rd_if.SLV_M1     = 4'd2;
    step("t1_grant");
    check("t1_ar_const",  8'(rd_if.AR_arbiter), 8'h12);
    check("t1_gnt_const", 8'(rd_if.GNT_M),      8'b010);
    rd_if.ARREADY_SEL = 1'b1;
    step("t1_hs");
    check("t1_gnt_off", 8'(rd_if.GNT_M), 8'd0);
    rd_if.ARVALID_M1  = 1'b0;
    rd_if.ARREADY_SEL = 1'b0;
    rd_if.SLV_M1      = 4'd7;
    for (int b = 1; b <= 3; b++) begin
      set_r(1'b1, 1'b1, 1'b0);
      step("t2_beat");
      check("t2_ar_held", 8'(rd_if.AR_arbiter), 8'h12);
    end
    set_r(1'b1, 1'b1, 1'b1);
    step("t2_last");
    check("t2_ar_idle", 8'(rd_if.AR_arbiter), 8'h3F);
    check("t2_busy_lo", 8'(rd_if.BUSY),       8'd0);
    clear_inputs();

    // M2 with out-of-range slave code; later SLV change ignored
    rd_if.ARVALID_M2 = 1'b1;
    rd_if.SLV_M2     = 4'hB;
    step("t4_grant");
    check("t4_ar_const", 8'(rd_if.AR_arbiter), 8'h28);
    rd_if.SLV_M2      = 4'h3;
    rd_if.ARREADY_SEL = 1'b1;
    step("t4_hs");
    check("t4_ar_latched", 8'(rd_if.AR_arbiter), 8'h28);
    rd_if.ARVALID_M2  = 1'b0;
    rd_if.ARREADY_SEL = 1'b0;
    set_r(1'b1, 1'b1, 1'b1);
    step("t4_last");
    clear_inputs();

    // All masters requesting, single-beat reads: round robin 0,1,2,0
    for (int i = 0; i < 4; i++) begin
      rd_if.ARVALID_M0 = 1'b1;
      rd_if.ARVALID_M1 = 1'b1;
      rd_if.ARVALID_M2 = 1'b1;
      rd_if.SLV_M0     = 4'($urandom_range(0, 15));
      rd_if.SLV_M1     = 4'($urandom_range(0, 15));
      rd_if.SLV_M2     = 4'($urandom_range(0, 15));
      rd_if.ARREADY_SEL = 1'b0;
      set_r(1'b0, 1'b0, 1'b0);
      step("t3_grant");
      check("t3_mst", 8'(rd_if.AR_arbiter[5:4]), 8'(order[i]));
      rd_if.ARREADY_SEL = 1'b1;
      step("t3_hs");
      rd_if.ARREADY_SEL = 1'b0;
      set_r(1'b1, 1'b1, 1'b1);
      step("t3_last");
    end
    clear_inputs();

    // Reset during beat 2 of an 8-beat burst
    rd_if.ARVALID_M1 = 1'b1;
    rd_if.SLV_M1     = 4'd5;
    step("t5_grant");
    rd_if.ARREADY_SEL = 1'b1;
    step("t5_hs");
    rd_if.ARVALID_M1  = 1'b0;
    rd_if.ARREADY_SEL = 1'b0;
    set_r(1'b1, 1'b1, 1'b0);
    step("t5_beat1");
    ARESET = 1'b1;
    #1;
    model_reset();
    check_outputs("t5_async_rst");
    @(negedge ACLK);
    ARESET = 1'b0;
    clear_inputs();
    rd_if.ARVALID_M0 = 1'b1;
    rd_if.ARVALID_M1 = 1'b1;
    rd_if.ARVALID_M2 = 1'b1;
    step("t5_regrant");
    check("t5_mst0", 8'(rd_if.AR_arbiter[5:4]), 8'd0);
    clear_inputs();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rd_if.ARVALID_M0  = 1'($urandom_range(0, 1));
      rd_if.ARVALID_M1  = 1'($urandom_range(0, 1));
      rd_if.ARVALID_M2  = 1'($urandom_range(0, 1));
      rd_if.SLV_M0      = 4'($urandom_range(0, 15));
      rd_if.SLV_M1      = 4'($urandom_range(0, 15));
      rd_if.SLV_M2      = 4'($urandom_range(0, 15));
      rd_if.ARREADY_SEL = 1'($urandom_range(0, 1));
      set_r(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      step("rand");
    end

`ifdef RD_TIMEOUT_EN
    // Slave never returns data: watchdog fires 16 cycles after entering ADDR
    clear_inputs();
    ARESET = 1'b1;
    #1;
    model_reset();
    @(negedge ACLK);
    ARESET = 1'b0;
    rd_if.ARVALID_M0 = 1'b1;
    step("to_grant");
    rd_if.ARREADY_SEL = 1'b1;
    step("to_hs");
    clear_inputs();
    pulses   = 0;
    pulse_at = -1;
    for (int i = 0; i < 20; i++) begin
      step("to_wait");
      if (rd_if.RD_TIMEOUT) begin
        pulses++;
        pulse_at = i;
      end
    end
    check("to_pulses", 8'(pulses),   8'd1);
    check("to_when",   8'(pulse_at), 8'd14);
`else
    pulses   = 0;
    pulse_at = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
